// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a downstream JK master-slave flop: drives J/K for one edge,
// lets the flop settle, then verifies Q/Qn against the expected next state.
module jk_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  output logic             J,
  output logic             K,
  input  logic             Q_fb,
  input  logic             Qn_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] cmd_cnt
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK
  } state_t;

  state_t        r_state;
  logic          r_exp;
  logic [SW-1:0] r_settle;

  logic w_accept;
  logic w_exp_next;
  logic w_mismatch;

  always_comb begin
    w_accept = (r_state == S_IDLE) && cmd_valid && cmd_ready;
    case (cmd_op)
      2'b00:   w_exp_next = Q_fb;
      2'b01:   w_exp_next = 1'b0;
      2'b10:   w_exp_next = 1'b1;
      default: w_exp_next = ~Q_fb;
    endcase
    // Q/Qn must be complementary as well as match, catching stuck-equal outputs.
    w_mismatch = (Q_fb != r_exp) || (Qn_fb == Q_fb);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_INIT;
      r_exp     <= 1'b0;
      r_settle  <= '0;
      cmd_ready <= 1'b0;
      J         <= 1'b0;
      K         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (err_clr) err <= 1'b0;
      case (r_state)
        S_INIT: begin
          cmd_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        S_IDLE: begin
          if (w_accept) begin
            r_exp     <= w_exp_next;
            J         <= cmd_op[1];
            K         <= cmd_op[0];
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            r_state   <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          J        <= 1'b0;
          K        <= 1'b0;
          r_settle <= SW'(SETTLE_CYCLES - 1);
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle == '0) r_state <= S_CHECK;
          else r_settle <= r_settle - 1'b1;
        end
        S_CHECK: begin
          done      <= 1'b1;
          cmd_cnt   <= cmd_cnt + 1'b1;
          // Placed after the clear so a coincident mismatch keeps err set.
          if (w_mismatch) err <= 1'b1;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          J         <= 1'b0;
          K         <= 1'b0;
          cmd_ready <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_INIT;
        end
      endcase
    end
  end

endmodule
